// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin packet-locking FIFO arbiter.
//   arb_state_t    : arbiter FSM encoding (IDLE / LOCKED)
//   idx_width()    : bit width of a port index for a given port count
//   ports_in_range : legal port-count check used at elaboration
package rr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned MIN_PORTS = 2;
    localparam int unsigned MAX_PORTS = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit ports_in_range(input int unsigned n);
        return (n >= MIN_PORTS) && (n <= MAX_PORTS);
    endfunction

endpackage

// File: rtl/rr_fifo_arbiter_if.sv
// FIFO-side signal bundle of the arbiter.
//   in_empty/in_data/in_last : per-port ingress FIFO head (port i data at [i*WIDTH +: WIDTH])
//   in_rdreq                 : per-port pop, one-hot or zero
//   out_full                 : egress FIFO full
//   out_wrreq/out_data/out_last : egress FIFO write
// Handshake: a beat moves from port s to the egress FIFO in exactly the cycle where
// in_rdreq[s] and out_wrreq are both high; the arbiter only raises them when
// in_empty[s]=0 and out_full=0, so both FIFOs see the pop/push on the same edge.
// modport master: arbiter side. modport slave: FIFO/environment side.
interface rr_fifo_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32
);
    logic [NUM_PORTS-1:0]       in_empty;
    logic [NUM_PORTS*WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]       in_last;
    logic [NUM_PORTS-1:0]       in_rdreq;
    logic                       out_full;
    logic                       out_wrreq;
    logic [WIDTH-1:0]           out_data;
    logic                       out_last;

    modport master (
        input  in_empty, in_data, in_last, out_full,
        output in_rdreq, out_wrreq, out_data, out_last
    );

    modport slave (
        output in_empty, in_data, in_last, out_full,
        input  in_rdreq, out_wrreq, out_data, out_last
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: returns the first asserted request at or above ptr,
// wrapping from N-1 back to 0.
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   any : at least one request asserted
//   idx : winning index (0 when any=0)
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    // (base + off) mod N for base < N, off < N; one conditional subtract suffices.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(off);
        if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
        return s[IW-1:0];
    endfunction

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = wrap_add(ptr, k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// N-way round-robin, packet-locking arbiter from per-port ingress FIFOs to one
// egress FIFO. A port that starts a packet keeps the grant until its last beat
// moves, or until MAX_BEATS beats have moved (watchdog release, err_overlong pulse).
//   clock, reset  : single clock, synchronous active-high reset
//   bus           : FIFO-side signals (rr_fifo_arbiter_if.master)
//   grant_valid   : registered, high while a packet is locked
//   grant_idx     : registered, port of the most recent transfer
//   err_overlong  : registered one-cycle pulse after a watchdog release
//   dbg_state     : current FSM state
module rr_fifo_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic                              clock,
    input  logic                              reset,
    rr_fifo_arbiter_if.master                 bus,
    output logic                              grant_valid,
    output logic [idx_width(NUM_PORTS)-1:0]   grant_idx,
    output logic                              err_overlong,
    output arb_state_t                        dbg_state
);

    localparam int IW = idx_width(NUM_PORTS);
    localparam int CW = $clog2(MAX_BEATS + 1);

    if (!ports_in_range(NUM_PORTS)) begin : g_bad_ports
        $error("rr_fifo_arbiter: NUM_PORTS must be 2..16");
    end

    arb_state_t     state, state_nxt;
    logic [IW-1:0]  ptr, ptr_nxt;
    logic [IW-1:0]  lock_idx, lock_nxt;
    logic [CW-1:0]  beat_cnt, cnt_nxt;
    logic           wd_fire;

    logic           pick_any;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  sel;
    logic           sel_ready;
    logic           sel_last;
    logic           xfer;
    logic [WIDTH-1:0] data_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign data_arr[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    rr_priority_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_pick (
        .req (~bus.in_empty),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_PORTS - 1)) ? '0 : v + IW'(1);
    endfunction

    // While locked only the owner may move; other ports are ignored.
    assign sel       = (state == LOCKED) ? lock_idx : pick_idx;
    assign sel_ready = (state == LOCKED) ? ~bus.in_empty[lock_idx] : pick_any;
    assign sel_last  = bus.in_last[sel];
    // Reset gates the strobes so nothing is popped or pushed while it is held.
    assign xfer      = sel_ready & ~bus.out_full & ~reset;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            lock_idx     <= '0;
            beat_cnt     <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            err_overlong <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            lock_idx     <= lock_nxt;
            beat_cnt     <= cnt_nxt;
            grant_valid  <= (state_nxt == LOCKED);
            err_overlong <= wd_fire;
            if (xfer) grant_idx <= sel;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_idx;
        cnt_nxt   = beat_cnt;
        wd_fire   = 1'b0;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (sel_last) begin
                        ptr_nxt = wrap_inc(sel);
                    end else begin
                        state_nxt = LOCKED;
                        lock_nxt  = sel;
                        cnt_nxt   = CW'(1);
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_nxt = IDLE;
                        ptr_nxt   = wrap_inc(lock_idx);
                        cnt_nxt   = '0;
                    end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
                        // This beat is the MAX_BEATS-th: release; the rest of the
                        // packet competes again as fresh traffic.
                        state_nxt = IDLE;
                        ptr_nxt   = wrap_inc(lock_idx);
                        cnt_nxt   = '0;
                        wd_fire   = 1'b1;
                    end else begin
                        cnt_nxt = beat_cnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.in_rdreq  = '0;
        bus.out_wrreq = xfer;
        bus.out_data  = data_arr[sel];
        bus.out_last  = sel_last;
        if (xfer) bus.in_rdreq[sel] = 1'b1;
    end

    assign dbg_state = state;

endmodule
